clk_or4_src_sel_ctrl: RTL and testbench
=======================================

Name: clk_or4_src_sel_ctrl

Overview:
- Single-clock controller that generates the four one-hot clock-gate enables whose gated clocks feed the 4-input clock OR cell.
- Switching is break-before-make: the old enable drops, all enables stay low for a programmable drain time, then the new enable rises. This keeps at most one gated clock toggling into the OR at any time.
- Sits in the clock-generation block, driven by a software/PMU select request over a req/ack handshake.

Parameters:
- SWITCH_WAIT, 4, cycles all enables are held low between deassertion of the old and assertion of the new enable; legal range 1 .. 2^CNT_W-1; elaboration error otherwise.
- CNT_W, 4, width of the drain counter.
- RESET_SEL, 0, source enabled out of reset; legal range 0..3; elaboration error otherwise.

Ports:
- i_clk  input  1  control clock; free-running, independent of the four gated sources.
- i_rst  input  1  reset; synchronous, active-high.
- i_req  input  1  switch request; sampled only while idle.
- i_sel  input  2  requested source index, valid with i_req.
- o_ack  output 1  one-cycle pulse; the request is complete.
- o_busy output 1  high while draining.
- o_en   output 4  one-hot (or all-zero) clock-gate enables; bit n gates source n into OR input n.
- o_cur_sel output 2  index of the currently enabled source.

Behaviour:
- All outputs are registered. No combinational path exists from inputs to outputs.
- Reset (i_rst high at an edge):
  - o_en = one-hot(RESET_SEL); o_cur_sel = RESET_SEL.
  - o_ack = 0; o_busy = 0; state = IDLE; counter = 0.
  - Reset mid-drain aborts the switch. The reset source is enabled on the cycle after the reset edge, and no ack is produced.
- States: IDLE, DRAIN (plus OFF when the optional feature is compiled in).
- IDLE, i_req=0: outputs hold; o_ack = 0.
- IDLE, i_req=1, i_sel == o_cur_sel, and o_en nonzero (same source requested):
  - o_en unchanged.
  - o_ack = 1 for the single cycle after the accepting edge.
  - Stay in IDLE.
- IDLE, i_req=1, any other case (accepting edge E0):
  - Latch i_sel as target.
  - o_en <= 0; o_busy <= 1; counter <= SWITCH_WAIT; go to DRAIN.
- DRAIN:
  - Counter decrements each edge.
  - At the edge where the counter equals 1:
    - o_en <= one-hot(target); o_cur_sel <= target.
    - o_busy <= 0; o_ack <= 1 (one cycle); go to IDLE.
  - Net timing: o_en is all-zero for exactly SWITCH_WAIT cycles. The new enable and o_ack are both visible after edge E_SWITCH_WAIT.
- o_cur_sel changes only when the new enable rises. It holds the old value throughout DRAIN.
- i_req and i_sel are ignored while o_busy = 1. They are not queued.
- The requester must drop i_req in the cycle o_ack is high. If i_req is still high in that cycle, it is sampled in IDLE on the next edge and treated as a new request.
- Invariant: popcount(o_en) <= 1 on every cycle.

Optional Feature:
- Macro: CLK_OR4_SRC_SEL_OFF_EN.
- With the macro defined:
  - Adds input i_off (1 bit), qualified by i_req.
  - A request with i_off=1 drains for SWITCH_WAIT cycles exactly as a normal switch, then enters OFF with o_en = 0 and pulses o_ack. o_cur_sel keeps the last enabled index.
  - In OFF, any request with i_off=0 (including one for the same index) performs a normal drain-and-enable.
  - A request with i_off=1 while in OFF acks next cycle with no drain.
- Without the macro:
  - The port and the OFF state do not exist.
  - o_en is never all-zero outside DRAIN.

Test Plan:
- Reset, default params: release i_rst -> o_en=4'b0001, o_cur_sel=0, o_ack=0, o_busy=0 on the first cycle after the reset edge.
- Switch 0->2, SWITCH_WAIT=4: pulse i_req with i_sel=2 -> o_en=0 and o_busy=1 for exactly 4 cycles, then o_en=4'b0100, o_cur_sel=2, one-cycle o_ack.
- Same-source request: from source 2, request i_sel=2 -> o_ack on the next cycle, o_en stays 4'b0100, o_busy never rises.
- Request during drain: switch 2->3 with SWITCH_WAIT=4, and assert i_req with i_sel=1 on the 2nd drain cycle -> ignored; final o_en=4'b1000, exactly one o_ack.
- Reset mid-drain: RESET_SEL=1, assert i_rst on the 3rd drain cycle -> o_en=4'b0010 on the next cycle, no o_ack. Check popcount(o_en) <= 1 throughout, including during a held i_req back-to-back switch 0->3->1 with SWITCH_WAIT=1.
- CLK_OR4_SRC_SEL_OFF_EN: request i_off=1 from source 1 -> 4 zero cycles, then OFF with o_en=0, o_cur_sel=1 and o_ack; then request i_sel=1, i_off=0 -> drain, then o_en=4'b0010.

Source files
------------

// File: rtl/clk_or4_src_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_or4_src_sel_ctrl
// Purpose  : Break-before-make select controller for a 4-input clock OR cell.
//            Produces four one-hot clock-gate enables. On a switch, the old
//            enable drops, all enables stay low for SWITCH_WAIT cycles so the
//            old gated clock can drain, and then the new enable rises.
// Ports    : i_clk      control clock (free-running)
//            i_rst      synchronous active-high reset
//            i_req      switch request, sampled only while idle
//            i_sel[1:0] requested source index, valid with i_req
//            i_off      (CLK_OR4_SRC_SEL_OFF_EN only) request all-off
//            o_ack      one-cycle completion pulse
//            o_busy     high while draining
//            o_en[3:0]  one-hot (or all-zero) clock-gate enables
//            o_cur_sel  index of the currently enabled source
// Options  : define CLK_OR4_SRC_SEL_OFF_EN to add the i_off port and OFF state
// Revision : 1.0 - initial release
// ============================================================================
module clk_or4_src_sel_ctrl #(
    parameter int SWITCH_WAIT = 4,
    parameter int CNT_W       = 4,
    parameter int RESET_SEL   = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic [1:0] i_sel,
`ifdef CLK_OR4_SRC_SEL_OFF_EN
    input  logic       i_off,
`endif
    output logic       o_ack,
    output logic       o_busy,
    output logic [3:0] o_en,
    output logic [1:0] o_cur_sel
);

    generate
        if (SWITCH_WAIT < 1 || SWITCH_WAIT > (2**CNT_W) - 1) begin : g_bad_switch_wait
            $error("clk_or4_src_sel_ctrl: SWITCH_WAIT out of range");
        end
        if (RESET_SEL < 0 || RESET_SEL > 3) begin : g_bad_reset_sel
            $error("clk_or4_src_sel_ctrl: RESET_SEL out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_WAIT      = CNT_W'(SWITCH_WAIT);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       c_RESET_SEL = 2'(RESET_SEL);
    localparam logic [3:0]       c_RESET_EN  = 4'b0001 << c_RESET_SEL;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef CLK_OR4_SRC_SEL_OFF_EN
        ST_OFF   = 2'd2,
`endif
        ST_DRAIN = 2'd1
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [1:0]       r_tgt,   w_tgt;
    logic [3:0]       r_en,    w_en;
    logic [1:0]       r_cur,   w_cur;
    logic             r_ack,   w_ack;
    logic             r_busy,  w_busy;
`ifdef CLK_OR4_SRC_SEL_OFF_EN
    logic             r_tgt_off, w_tgt_off;
`endif

    // Next-state and next-output logic. Every output is taken from a
    // register, so nothing here reaches a port combinationally.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_tgt   = r_tgt;
        w_en    = r_en;
        w_cur   = r_cur;
        w_ack   = 1'b0;
        w_busy  = r_busy;
`ifdef CLK_OR4_SRC_SEL_OFF_EN
        w_tgt_off = r_tgt_off;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
`ifdef CLK_OR4_SRC_SEL_OFF_EN
                    if (!i_off && i_sel == r_cur && r_en != 4'b0000) begin
`else
                    if (i_sel == r_cur && r_en != 4'b0000) begin
`endif
                        // Already running from this source: acknowledge only.
                        w_ack = 1'b1;
                    end else begin
                        w_tgt   = i_sel;
                        w_en    = 4'b0000;
                        w_busy  = 1'b1;
                        w_cnt   = c_WAIT;
                        w_state = ST_DRAIN;
`ifdef CLK_OR4_SRC_SEL_OFF_EN
                        w_tgt_off = i_off;
`endif
                    end
                end
            end
            ST_DRAIN: begin
                if (r_cnt == c_CNT_ONE) begin
                    // Last drain cycle: new enable and ack land together.
                    w_busy = 1'b0;
                    w_ack  = 1'b1;
`ifdef CLK_OR4_SRC_SEL_OFF_EN
                    if (r_tgt_off) begin
                        // Stay dark; o_cur_sel keeps the last enabled index.
                        w_state = ST_OFF;
                    end else begin
                        w_en    = 4'b0001 << r_tgt;
                        w_cur   = r_tgt;
                        w_state = ST_IDLE;
                    end
`else
                    w_en    = 4'b0001 << r_tgt;
                    w_cur   = r_tgt;
                    w_state = ST_IDLE;
`endif
                end else begin
                    w_cnt = r_cnt - c_CNT_ONE;
                end
            end
`ifdef CLK_OR4_SRC_SEL_OFF_EN
            ST_OFF: begin
                if (i_req) begin
                    if (i_off) begin
                        // Already off: nothing to drain.
                        w_ack = 1'b1;
                    end else begin
                        w_tgt     = i_sel;
                        w_tgt_off = 1'b0;
                        w_busy    = 1'b1;
                        w_cnt     = c_WAIT;
                        w_state   = ST_DRAIN;
                    end
                end
            end
`endif
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tgt   <= c_RESET_SEL;
            r_en    <= c_RESET_EN;
            r_cur   <= c_RESET_SEL;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef CLK_OR4_SRC_SEL_OFF_EN
            r_tgt_off <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_tgt   <= w_tgt;
            r_en    <= w_en;
            r_cur   <= w_cur;
            r_ack   <= w_ack;
            r_busy  <= w_busy;
`ifdef CLK_OR4_SRC_SEL_OFF_EN
            r_tgt_off <= w_tgt_off;
`endif
        end
    end

    assign o_ack     = r_ack;
    assign o_busy    = r_busy;
    assign o_en      = r_en;
    assign o_cur_sel = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_clk_or4_src_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_or4_src_sel_ctrl
// Purpose  : Directed self-checking bench for clk_or4_src_sel_ctrl.
//            Instance A: defaults (SWITCH_WAIT=4, RESET_SEL=0)
//            Instance B: RESET_SEL=1, SWITCH_WAIT=4
//            Instance C: SWITCH_WAIT=1, back-to-back switching
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_or4_src_sel_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_req, b_rst, b_req, c_rst, c_req;
    logic [1:0] a_sel, b_sel, c_sel;
    logic       a_off, b_off, c_off;
    logic       a_ack, a_busy, b_ack, b_busy, c_ack, c_busy;
    logic [3:0] a_en, b_en, c_en;
    logic [1:0] a_cur, b_cur, c_cur;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    clk_or4_src_sel_ctrl u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_req(a_req), .i_sel(a_sel),
`ifdef CLK_OR4_SRC_SEL_OFF_EN
        .i_off(a_off),
`endif
        .o_ack(a_ack), .o_busy(a_busy), .o_en(a_en), .o_cur_sel(a_cur)
    );

    clk_or4_src_sel_ctrl #(.SWITCH_WAIT(4), .RESET_SEL(1)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_req(b_req), .i_sel(b_sel),
`ifdef CLK_OR4_SRC_SEL_OFF_EN
        .i_off(b_off),
`endif
        .o_ack(b_ack), .o_busy(b_busy), .o_en(b_en), .o_cur_sel(b_cur)
    );

    clk_or4_src_sel_ctrl #(.SWITCH_WAIT(1), .RESET_SEL(0)) u_dut_c (
        .i_clk(clk), .i_rst(c_rst), .i_req(c_req), .i_sel(c_sel),
`ifdef CLK_OR4_SRC_SEL_OFF_EN
        .i_off(c_off),
`endif
        .o_ack(c_ack), .o_busy(c_busy), .o_en(c_en), .o_cur_sel(c_cur)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // At most one enable may be high at any time, on every instance.
    always @(negedge clk) begin
        if (mon_on) begin
            check("popcnt_a", 32'($countones(a_en) <= 1), 32'd1);
            check("popcnt_b", 32'($countones(b_en) <= 1), 32'd1);
            check("popcnt_c", 32'($countones(c_en) <= 1), 32'd1);
        end
    end

    initial begin
        int acks;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
        a_sel = 2'd0; b_sel = 2'd0; c_sel = 2'd0;
        a_off = 1'b0; b_off = 1'b0; c_off = 1'b0;
        tick();
        tick();
        // First cycle after a reset edge.
        check("rst_a_en",   32'(a_en),   32'h1);
        check("rst_a_cur",  32'(a_cur),  32'h0);
        check("rst_a_ack",  32'(a_ack),  32'h0);
        check("rst_a_busy", 32'(a_busy), 32'h0);
        check("rst_b_en",   32'(b_en),   32'h2);
        check("rst_b_cur",  32'(b_cur),  32'h1);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        mon_on = 1'b1;
        tick();

        // ---- A: switch 0 -> 2, four all-zero busy cycles ----
        a_req = 1'b1; a_sel = 2'd2;
        tick();
        a_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("sw02_en",   32'(a_en),   32'h0);
            check("sw02_busy", 32'(a_busy), 32'h1);
            check("sw02_ack",  32'(a_ack),  32'h0);
            check("sw02_cur",  32'(a_cur),  32'h0);
            tick();
        end
        check("sw02_en_new", 32'(a_en),   32'h4);
        check("sw02_cur2",   32'(a_cur),  32'h2);
        check("sw02_ack1",   32'(a_ack),  32'h1);
        check("sw02_busy0",  32'(a_busy), 32'h0);
        tick();
        check("sw02_ack_pulse", 32'(a_ack), 32'h0);

        // ---- A: same-source request ----
        a_req = 1'b1; a_sel = 2'd2;
        tick();
        a_req = 1'b0;
        check("same_ack",  32'(a_ack),  32'h1);
        check("same_en",   32'(a_en),   32'h4);
        check("same_busy", 32'(a_busy), 32'h0);
        tick();
        check("same_ack_end", 32'(a_ack),  32'h0);
        check("same_busy2",   32'(a_busy), 32'h0);

        // ---- A: switch 2 -> 3 with a request injected during drain ----
        acks = 0;
        a_req = 1'b1; a_sel = 2'd3;
        tick();
        a_req = 1'b0;
        tick();
        a_req = 1'b1; a_sel = 2'd1;
        tick();
        a_req = 1'b0;
        check("ign_busy", 32'(a_busy), 32'h1);
        for (int k = 0; k < 8; k++) begin
            if (a_ack) acks++;
            tick();
        end
        check("ign_en",   32'(a_en),  32'h8);
        check("ign_cur",  32'(a_cur), 32'h3);
        check("ign_acks", 32'(acks),  32'd1);

        // ---- B: reset on the 3rd drain cycle aborts the switch ----
        b_req = 1'b1; b_sel = 2'd3;
        tick();
        b_req = 1'b0;
        tick();
        tick();
        check("rmd_busy", 32'(b_busy), 32'h1);
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        check("rmd_en",   32'(b_en),   32'h2);
        check("rmd_cur",  32'(b_cur),  32'h1);
        check("rmd_ack",  32'(b_ack),  32'h0);
        check("rmd_busy0", 32'(b_busy), 32'h0);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            if (b_ack) acks++;
            tick();
        end
        check("rmd_noack", 32'(acks), 32'd0);
        check("rmd_en2",   32'(b_en), 32'h2);

        // ---- C: held i_req back-to-back 0 -> 3 -> 1, SWITCH_WAIT=1 ----
        c_req = 1'b1; c_sel = 2'd3;
        tick();
        check("b2b_en0",   32'(c_en),   32'h0);
        check("b2b_busy0", 32'(c_busy), 32'h1);
        tick();
        check("b2b_en3",  32'(c_en),  32'h8);
        check("b2b_cur3", 32'(c_cur), 32'h3);
        check("b2b_ack3", 32'(c_ack), 32'h1);
        c_sel = 2'd1;
        tick();
        check("b2b_en0b",  32'(c_en),   32'h0);
        check("b2b_busyb", 32'(c_busy), 32'h1);
        check("b2b_ackb",  32'(c_ack),  32'h0);
        tick();
        c_req = 1'b0;
        check("b2b_en1",  32'(c_en),  32'h2);
        check("b2b_cur1", 32'(c_cur), 32'h1);
        check("b2b_ack1", 32'(c_ack), 32'h1);
        tick();
        check("b2b_ack_end", 32'(c_ack), 32'h0);
        check("b2b_en_hold", 32'(c_en),  32'h2);

`ifdef CLK_OR4_SRC_SEL_OFF_EN
        // ---- B: switch off from source 1, then back on to source 1 ----
        b_req = 1'b1; b_sel = 2'd1; b_off = 1'b1;
        tick();
        b_req = 1'b0; b_off = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("off_drain_en",   32'(b_en),   32'h0);
            check("off_drain_busy", 32'(b_busy), 32'h1);
            tick();
        end
        check("off_en",   32'(b_en),   32'h0);
        check("off_cur",  32'(b_cur),  32'h1);
        check("off_ack",  32'(b_ack),  32'h1);
        check("off_busy", 32'(b_busy), 32'h0);
        tick();
        b_req = 1'b1; b_sel = 2'd1; b_off = 1'b1;
        tick();
        b_req = 1'b0; b_off = 1'b0;
        check("offoff_ack",  32'(b_ack),  32'h1);
        check("offoff_busy", 32'(b_busy), 32'h0);
        tick();
        b_req = 1'b1; b_sel = 2'd1;
        tick();
        b_req = 1'b0;
        check("on_busy", 32'(b_busy), 32'h1);
        tick();
        tick();
        tick();
        tick();
        check("on_en",  32'(b_en),  32'h2);
        check("on_ack", 32'(b_ack), 32'h1);
`endif

        tick();
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
